// File: rtl/arb17_rr.sv
`default_nettype none
// ============================================================================
// Module   : arb17_rr
// Brief    : 17-way round-robin arbiter with watchdog, drives a 5-bit mux select
// Revision : 1.0 - initial release
// ============================================================================
module arb17_rr #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] req,
    input  logic        done,
    output logic [4:0]  sel,
    output logic [16:0] grant,
    output logic        grant_valid,
    output logic        timeout
);

    localparam int CNT_W = $clog2(HOLD_MAX) + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [4:0]         ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic [4:0]         win_idx;
    logic               win_found;
    logic [5:0]         scan_sum;
    logic [4:0]         scan_idx;

    logic               take_grant;
    logic               release_now;
    logic               wd_expire;
    logic [4:0]         ptr_after;

    // Circular priority scan starting at ptr; first set request wins.
    always_comb begin
        win_idx   = 5'd0;
        win_found = 1'b0;
        scan_sum  = 6'd0;
        scan_idx  = 5'd0;
        for (int i = 0; i < 17; i++) begin
            scan_sum = 6'(ptr) + 6'(i);
            if (scan_sum >= 6'd17) begin
                scan_sum = scan_sum - 6'd17;
            end
            scan_idx = scan_sum[4:0];
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // The watchdog only counts as the release cause when done is absent.
    always_comb begin
        state_next  = state;
        take_grant  = 1'b0;
        release_now = 1'b0;
        wd_expire   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    take_grant = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (done) begin
                    release_now = 1'b1;
                    state_next  = IDLE;
                end else if (hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
                    release_now = 1'b1;
                    wd_expire   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ptr_after = (sel == 5'd16) ? 5'd0 : sel + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= 5'd0;
            sel         <= 5'd0;
            grant       <= 17'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            timeout <= wd_expire;
            if (take_grant) begin
                sel         <= win_idx;
                grant       <= 17'd1 << win_idx;
                grant_valid <= 1'b1;
                hold_cnt    <= '0;
            end else if (release_now) begin
                grant       <= 17'd0;
                grant_valid <= 1'b0;
                ptr         <= ptr_after;
                hold_cnt    <= '0;
            end else if (state == GRANT) begin
                hold_cnt    <= hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/arb17_rr.md
# arb17_rr

Round-robin arbiter and sequencer for a shared 17-input, 5-bit-select datapath mux. Accepts up to 17 requesters, grants exactly one at a time, drives the mux select with the winner's index, and holds the grant until the owner signals completion or a watchdog expires. Sits in front of the shared-resource mux in the datapath and supplies its 5-bit select.

## Interface
- HOLD_MAX, 16: maximum cycles a grant is held without `done` before forced release; legal range 2..255.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  17  per-requester request level; bit i = requester i.
- done  input  1  current owner finished; sampled only while `grant_valid`=1.
- sel  output  5  registered mux select = index of current/last winner (0..16, binary).
- grant  output  17  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  registered; 1 while a grant is held.
- timeout  output  1  registered one-cycle pulse when a grant is force-released by the watchdog.

## Operation
- Internal state: FSM {IDLE, GRANT}; 5-bit round-robin pointer `ptr` (0..16); winner index; hold counter of width clog2(HOLD_MAX)+1.
- Reset values: state IDLE, ptr 0, sel 0, grant 0, grant_valid 0, timeout 0, hold counter 0.
- IDLE: if req != 0, winner = first set bit scanning ptr, ptr+1, ..., 16, 0, ..., ptr-1 (circular). At the edge: state→GRANT, sel←winner, grant←one-hot(winner), grant_valid←1, counter←0. If req == 0, remain IDLE; sel holds its last value.
- GRANT: sel/grant constant; `req` changes ignored (requester dropping its req does not release). Counter increments each cycle.
  - `done`=1: at the edge, grant←0, grant_valid←0, ptr←winner+1 with 16→0 wrap, state→IDLE.
  - `done`=0 and counter == HOLD_MAX-1: forced release identical to the done case, plus timeout←1 for exactly one cycle.
  - `done` and watchdog expiry on the same cycle: treat as normal done; timeout stays 0.
- `done` while IDLE: ignored.
- sel never holds a value above 16; all 17 encodings 0..16 are reachable.
- reset asserted during GRANT: all state returns to reset values at that edge; no timeout pulse; ptr returns to 0.

## Timing
- Grant latency: req seen in IDLE at edge N → grant_valid=1, sel valid after edge N (1 cycle).
- Release: done=1 sampled at edge M → grant_valid=0 after edge M.
- Mandatory one-cycle IDLE bubble between grants: next grant asserts after edge M+1 at the earliest; back-to-back ownership spacing = hold cycles + 1.
- Maximum hold: grant_valid high for exactly HOLD_MAX cycles when done never arrives; timeout high in the first cycle after release.
- All outputs are flop outputs; no combinational path from req/done to any output.
- Fairness: with all 17 requesters continuously requesting, each wins exactly once per 17 grants, in index order.

## Test plan
- Reset, then req=17'h00004 → one cycle later grant=17'h00004, sel=2, grant_valid=1; done pulse → grant=0 next cycle, ptr=3.
- req=17'h1FFFF held, done asserted on the first cycle of each grant → winners 0,1,...,16,0 in order; sel wraps 16→0; grant every 2 cycles.
- ptr=16 (after winner 15), req=17'h00001|17'h10000 → winner 16; then winner 0 (circular wrap check).
- HOLD_MAX=16, req=17'h00100, done never asserted → grant_valid high exactly 16 cycles, timeout one-cycle pulse, sel=8; requester 8 regranted after the bubble, since it is the only requester.
- Owner drops req mid-grant, done low → grant held; done on the same cycle as watchdog expiry → release with timeout=0.
- reset asserted mid-grant (sel=5) → next cycle grant=0, grant_valid=0, sel=0, timeout=0; next req=17'h1FFFF grants 0.
